// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if
//   Bus between the processor-side writer and the display scan controller.
//   master: drives the write strobe/value, observes the scan outputs.
//   slave : the scan controller itself.
//   Signals:
//     data_i    [15:0] value to display, nibble k -> digit k (digit 0 rightmost)
//     we_i             single-cycle write strobe into the shadow register
//     Q_o       [1:0]  active digit index, to the anode decoder
//     digit_o   [3:0]  nibble of the active digit, to the segment decoder
//     blank_o          force all segments off for the active digit
//     tick_o           one-cycle pulse in the last cycle of each digit slot
//     pending_o        a written value is waiting for the next frame boundary
interface display_scan_ctrl_if;
    logic [15:0] data_i;
    logic        we_i;
    logic [1:0]  Q_o;
    logic [3:0]  digit_o;
    logic        blank_o;
    logic        tick_o;
    logic        pending_o;

    modport master (
        output data_i, we_i,
        input  Q_o, digit_o, blank_o, tick_o, pending_o
    );

    modport slave (
        input  data_i, we_i,
        output Q_o, digit_o, blank_o, tick_o, pending_o
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Scan controller for a 4-digit seven-segment display. Holds a 16-bit
//   value and cycles the active digit index at a rate of one digit per
//   REFRESH_DIV clocks. Writes land in a shadow register and are copied to
//   the display register only at a frame boundary (last cycle of digit 3),
//   so a frame never mixes old and new digits.
//
//   Parameters:
//     REFRESH_DIV  clocks per digit slot, legal 2..2**20
//   Ports:
//     clk_i        system clock
//     rst_n_i      asynchronous active-low reset
//     bus          display_scan_ctrl_if.slave (data_i/we_i in, scan outputs)
//   Build option:
//     LEADING_ZERO_BLANK_EN  when defined, leading-zero digits (never digit 0)
//                            assert blank_o; otherwise blank_o is tied low.
module display_scan_ctrl #(
    parameter int REFRESH_DIV = 10000
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    display_scan_ctrl_if.slave   bus
);

    localparam int              PRE_W    = $clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

    logic [PRE_W-1:0] pre;
    logic [1:0]       q;
    logic [15:0]      shd;
    logic [15:0]      disp;
    logic             pending;
    logic             tick;
    logic             frame_end;
    logic [3:0]       digit;
    logic             blank;

    // Decoded straight from the registered prescaler, so tick is glitch-free
    // relative to the clock and low while in reset.
    assign tick      = (pre == PRE_LAST);
    assign frame_end = tick && (q == 2'd3);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pre     <= '0;
            q       <= 2'd0;
            shd     <= 16'h0000;
            disp    <= 16'h0000;
            pending <= 1'b0;
        end else begin
            if (tick) begin
                pre <= '0;
                q   <= q + 2'd1;
            end else begin
                pre <= pre + PRE_W'(1);
            end

            if (bus.we_i) begin
                shd <= bus.data_i;
            end

            // disp takes the pre-write shd when a write coincides with the
            // boundary; the new write stays pending for the next frame.
            if (frame_end && pending) begin
                disp <= shd;
            end

            if (bus.we_i) begin
                pending <= 1'b1;
            end else if (frame_end) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        digit = disp[{q, 2'b00} +: 4];
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Digit k is a leading zero when it and every more-significant digit
    // are zero. Digit 0 always shows so that a value of 0 reads "0".
    always_comb begin
        blank = 1'b0;
        case (q)
            2'd1:    blank = (disp[15:4]  == 12'h000);
            2'd2:    blank = (disp[15:8]  == 8'h00);
            2'd3:    blank = (disp[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    assign bus.Q_o       = q;
    assign bus.digit_o   = digit;
    assign bus.blank_o   = blank;
    assign bus.tick_o    = tick;
    assign bus.pending_o = pending;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl
//   Directed bench for display_scan_ctrl with REFRESH_DIV=4. n counts clock
//   edges since the most recent reset release; outputs are sampled on the
//   falling edge and inputs are changed right after sampling.
module tb_display_scan_ctrl;

    localparam int RD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    display_scan_ctrl_if bus();

    display_scan_ctrl #(.REFRESH_DIV(RD)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n     = 0;

    typedef struct {
        logic        we;
        logic [15:0] data;
        logic [1:0]  q;
        logic [3:0]  digit;
        logic        tick;
        logic        pend;
        logic        blank;   // expected value when leading-zero blanking is built in
    } vec_t;

    vec_t vecs[32];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at n=%0d: got 0x%0h, expected 0x%0h", name, n, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] q, input logic [3:0] d,
                             input logic t, input logic p, input logic b);
        logic b_exp;
`ifdef LEADING_ZERO_BLANK_EN
        b_exp = b;
`else
        b_exp = 1'b0;
`endif
        chk({tag, ".q"},       16'(bus.Q_o),       16'(q));
        chk({tag, ".digit"},   16'(bus.digit_o),   16'(d));
        chk({tag, ".tick"},    16'(bus.tick_o),    16'(t));
        chk({tag, ".pending"}, 16'(bus.pending_o), 16'(p));
        chk({tag, ".blank"},   16'(bus.blank_o),   16'(b_exp));
    endtask

    task automatic cyc();
        @(negedge clk);
        n++;
    endtask

    task automatic write(input logic [15:0] v);
        bus.we_i   = 1'b1;
        bus.data_i = v;
        cyc();
        bus.we_i   = 1'b0;
    endtask

    logic        seen_a;
    logic [15:0] beef;
    logic [3:0]  dg50 [4];
    logic        bl50 [4];
    logic        bl00 [4];

    initial begin
        bus.we_i   = 1'b0;
        bus.data_i = 16'h0000;
        beef       = 16'hBEEF;
        dg50       = '{4'h0, 4'h5, 4'h0, 4'h0};
        bl50       = '{1'b0, 1'b0, 1'b1, 1'b1};
        bl00       = '{1'b0, 1'b1, 1'b1, 1'b1};

        // Frame 0: blank display, write 0x1234 at n=6. Frame 1 shows it.
        //            we    data      q     digit  tick  pend  blank
        vecs[0]  = '{1'b0, 16'h0000, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 16'h0000, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 16'h0000, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 16'h0000, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 16'h0000, 2'd1, 4'h0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 16'h0000, 2'd1, 4'h0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 16'h1234, 2'd1, 4'h0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 16'h0000, 2'd1, 4'h0, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 16'h0000, 2'd2, 4'h0, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 16'h0000, 2'd2, 4'h0, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 16'h0000, 2'd2, 4'h0, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 16'h0000, 2'd2, 4'h0, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 16'h0000, 2'd3, 4'h0, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 16'h0000, 2'd3, 4'h0, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 16'h0000, 2'd3, 4'h0, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 16'h0000, 2'd3, 4'h0, 1'b1, 1'b1, 1'b1};
        vecs[16] = '{1'b0, 16'h0000, 2'd0, 4'h4, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 16'h0000, 2'd0, 4'h4, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 16'h0000, 2'd0, 4'h4, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 16'h0000, 2'd0, 4'h4, 1'b1, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 16'h0000, 2'd1, 4'h3, 1'b0, 1'b0, 1'b0};
        vecs[21] = '{1'b0, 16'h0000, 2'd1, 4'h3, 1'b0, 1'b0, 1'b0};
        vecs[22] = '{1'b0, 16'h0000, 2'd1, 4'h3, 1'b0, 1'b0, 1'b0};
        vecs[23] = '{1'b0, 16'h0000, 2'd1, 4'h3, 1'b1, 1'b0, 1'b0};
        vecs[24] = '{1'b0, 16'h0000, 2'd2, 4'h2, 1'b0, 1'b0, 1'b0};
        vecs[25] = '{1'b0, 16'h0000, 2'd2, 4'h2, 1'b0, 1'b0, 1'b0};
        vecs[26] = '{1'b0, 16'h0000, 2'd2, 4'h2, 1'b0, 1'b0, 1'b0};
        vecs[27] = '{1'b0, 16'h0000, 2'd2, 4'h2, 1'b1, 1'b0, 1'b0};
        vecs[28] = '{1'b0, 16'h0000, 2'd3, 4'h1, 1'b0, 1'b0, 1'b0};
        vecs[29] = '{1'b0, 16'h0000, 2'd3, 4'h1, 1'b0, 1'b0, 1'b0};
        vecs[30] = '{1'b0, 16'h0000, 2'd3, 4'h1, 1'b0, 1'b0, 1'b0};
        vecs[31] = '{1'b0, 16'h0000, 2'd3, 4'h1, 1'b1, 1'b0, 1'b0};

        // Reset values while reset is held.
        @(negedge clk);
        check_all("in_reset", 2'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        n     = 0;

        for (int r = 0; r < 32; r++) begin
            check_all($sformatf("vec%0d", r), vecs[r].q, vecs[r].digit,
                      vecs[r].tick, vecs[r].pend, vecs[r].blank);
            bus.we_i   = vecs[r].we;
            bus.data_i = vecs[r].data;
            cyc();
        end
        bus.we_i = 1'b0;

        // Last write before the boundary wins: 0xAAAA then 0x5555.
        seen_a = 1'b0;
        write(16'hAAAA);
        chk("aaaa.pending", 16'(bus.pending_o), 16'h1);
        while (n < 36) begin
            if (bus.digit_o == 4'hA) seen_a = 1'b1;
            cyc();
        end
        write(16'h5555);
        while (n < 47) begin
            if (bus.digit_o == 4'hA) seen_a = 1'b1;
            cyc();
        end
        check_all("pre5_bnd", 2'd3, 4'h1, 1'b1, 1'b1, 1'b0);
        cyc();
        for (int k = 0; k < 16; k++) begin
            if (bus.digit_o == 4'hA) seen_a = 1'b1;
            check_all("five", 2'(k / 4), 4'h5, (k % 4 == 3), 1'b0, 1'b0);
            cyc();
        end
        chk("no_a_seen", 16'(seen_a), 16'h0);

        // Write on the exact boundary edge while 0x1111 is pending.
        cyc();
        write(16'h1111);
        chk("p1111.pending", 16'(bus.pending_o), 16'h1);
        while (n < 79) cyc();
        check_all("pre1111_bnd", 2'd3, 4'h5, 1'b1, 1'b1, 1'b0);
        write(16'hBEEF);
        for (int k = 0; k < 16; k++) begin
            check_all("f1111", 2'(k / 4), 4'h1, (k % 4 == 3), 1'b1, 1'b0);
            cyc();
        end
        for (int k = 0; k < 16; k++) begin
            check_all("fbeef", 2'(k / 4), beef[4 * (k / 4) +: 4], (k % 4 == 3), 1'b0, 1'b0);
            cyc();
        end

        // Leading-zero blanking: 0x0050, then 0x0000; then a 1-cycle latency write.
        write(16'h0050);
        while (n < 128) cyc();
        for (int k = 0; k < 16; k++) begin
            check_all("z50", 2'(k / 4), dg50[k / 4], (k % 4 == 3), (k != 0), bl50[k / 4]);
            bus.we_i   = (k == 0);
            bus.data_i = 16'h0000;
            cyc();
        end
        for (int k = 0; k < 16; k++) begin
            check_all("z00", 2'(k / 4), 4'h0, (k % 4 == 3), (k == 15), bl00[k / 4]);
            bus.we_i   = (k == 14);
            bus.data_i = 16'h4321;
            cyc();
        end
        bus.we_i = 1'b0;
        check_all("minlat", 2'd0, 4'h1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-frame with a write pending.
        while (n < 165) cyc();
        write(16'h7777);
        chk("prerst.pending", 16'(bus.pending_o), 16'h1);
        chk("prerst.digit",   16'(bus.digit_o),   16'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async", 2'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        n     = 0;
        for (int k = 0; k < 20; k++) begin
            check_all("post_rst", 2'((k / 4) % 4), 4'h0, (k % 4 == 3), 1'b0, ((k / 4) % 4 != 0));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
